// File: rtl/visualizador_pkg.sv
// Shared constants and helpers for the numeric display capture path.
package visualizador_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [3:0] BCD_INVALIDO = 4'hF;

    localparam logic [1:0] ESPERA    = 2'd0;
    localparam logic [1:0] FILTRO    = 2'd1;
    localparam logic [1:0] CAPTURADO = 2'd2;

    // Anodes are active-low: exactly one zero selects a single digit.
    function automatic logic anodo_valido(input logic [3:0] anodos);
        case (anodos)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: anodo_valido = 1'b1;
            default:                            anodo_valido = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] indice_digito(input logic [3:0] anodos);
        case (anodos)
            4'b1101: indice_digito = 2'd1;
            4'b1011: indice_digito = 2'd2;
            4'b0111: indice_digito = 2'd3;
            default: indice_digito = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_7seg_bcd.sv
// Inverse seven-segment table: active-high gfedcba pattern back to BCD.
module decodificador_7seg_bcd
    import visualizador_pkg::*;
(
    input  logic [6:0] segmentos,
    output logic [3:0] bcd,
    output logic       valido
);

    always_comb begin
        bcd    = BCD_INVALIDO;
        valido = 1'b1;
        case (segmentos)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valido = 1'b0;
        endcase
    end

endmodule

// File: rtl/decodificador_visualizador_numerico.sv
// Samples the multiplexed display bus, filters each anode/segment pattern
// until stable, and keeps the last decoded value of each of the four digits.
module decodificador_visualizador_numerico
    import visualizador_pkg::*;
#(
    parameter int ESTABLE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] anodos,
    input  logic [7:0] segmentos,
    output logic [3:0] digito0,
    output logic [3:0] digito1,
    output logic [3:0] digito2,
    output logic [3:0] digito3,
    output logic [3:0] valido,
    output logic       frame_listo,
    output logic       error_codigo
);

    localparam logic [8:0] ESTABLE_L = 9'(ESTABLE);

    logic [11:0] p_reg;
    logic [11:0] p_prev;
    logic [1:0]  estado;
    logic [7:0]  cnt;
    logic [3:0]  visto;
    logic [3:0]  digitos [4];

    logic        anodo_ok;
    logic        cambio;
    logic [8:0]  cuenta_actual;
    logic [7:0]  cnt_sat;
    logic        captura;
    logic [1:0]  indice;
    logic [3:0]  visto_nuevo;
    logic [3:0]  bcd_dec;
    logic        valido_dec;

    decodificador_7seg_bcd u_decodificador (
        .segmentos (~p_reg[6:0]),
        .bcd       (bcd_dec),
        .valido    (valido_dec)
    );

    // cuenta_actual is the number of consecutive identical samples including
    // the one now in p_reg, so ESTABLE=1 captures on the first valid cycle.
    always_comb begin
        anodo_ok      = anodo_valido(p_reg[11:8]);
        cambio        = (p_reg != p_prev);
        cuenta_actual = (estado == ESPERA || cambio) ? 9'd1 : ({1'b0, cnt} + 9'd1);
        cnt_sat       = (cuenta_actual > ESTABLE_L) ? ESTABLE_L[7:0] : cuenta_actual[7:0];
        captura       = anodo_ok && (estado != CAPTURADO || cambio) &&
                        (cuenta_actual >= ESTABLE_L);
        indice        = indice_digito(p_reg[11:8]);
        visto_nuevo   = visto | (4'b0001 << indice);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_reg        <= 12'hFFF;
            p_prev       <= 12'hFFF;
            estado       <= ESPERA;
            cnt          <= 8'd0;
            visto        <= 4'd0;
            valido       <= 4'd0;
            frame_listo  <= 1'b0;
            error_codigo <= 1'b0;
            for (int i = 0; i < 4; i++) digitos[i] <= 4'd0;
        end else begin
            p_reg       <= {anodos, segmentos};
            p_prev      <= p_reg;
            frame_listo <= 1'b0;

            if (!anodo_ok) begin
                estado <= ESPERA;
                cnt    <= 8'd0;
            end else if (captura) begin
                estado <= CAPTURADO;
                cnt    <= cnt_sat;
            end else if (estado == CAPTURADO && !cambio) begin
                estado <= CAPTURADO;
            end else begin
                estado <= FILTRO;
                cnt    <= cnt_sat;
            end

            if (captura) begin
                digitos[indice] <= bcd_dec;
                valido[indice]  <= valido_dec;
                if (!valido_dec) error_codigo <= 1'b1;
                if (visto_nuevo == 4'hF) begin
                    frame_listo <= 1'b1;
                    visto       <= 4'd0;
                end else begin
                    visto <= visto_nuevo;
                end
            end
        end
    end

    assign digito0 = digitos[0];
    assign digito1 = digitos[1];
    assign digito2 = digitos[2];
    assign digito3 = digitos[3];

endmodule

// File: tb/tb_decodificador_visualizador_numerico.sv
// Directed bench for the display read-back decoder with hand-computed results.
module tb_decodificador_visualizador_numerico;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] anodos;
    logic [7:0] segmentos;
    logic [3:0] digito0, digito1, digito2, digito3;
    logic [3:0] valido;
    logic       frame_listo;
    logic       error_codigo;

    int checks = 0;
    int errors = 0;
    int frame_count = 0;

    decodificador_visualizador_numerico #(.ESTABLE(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .anodos       (anodos),
        .segmentos    (segmentos),
        .digito0      (digito0),
        .digito1      (digito1),
        .digito2      (digito2),
        .digito3      (digito3),
        .valido       (valido),
        .frame_listo  (frame_listo),
        .error_codigo (error_codigo)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (frame_listo) frame_count++;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] an, input logic [7:0] seg);
        anodos    = an;
        segmentos = seg;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(4'hF, 8'hFF);
        step(2);
        reset = 1'b0;
        check_output("reset_digitos", {digito3, digito2, digito1, digito0}, 16'h0000);
        check_output("reset_valido", valido, 4'h0);
        check_output("reset_error", error_codigo, 1'b0);
        check_output("reset_frame", frame_listo, 1'b0);

        // Single digit: capture exactly on the fifth edge.
        apply_stimulus(4'b1110, 8'hB0);
        step(4);
        check_output("lat_pre_valido", valido, 4'h0);
        step(1);
        check_output("lat_digito0", digito0, 4'd3);
        check_output("lat_valido", valido, 4'b0001);
        check_output("lat_frame", frame_listo, 1'b0);

        // Full frame 0..3; digit 0 already seen, pulse on digit 3 capture.
        apply_stimulus(4'b1110, 8'hC0); step(6);
        apply_stimulus(4'b1101, 8'hF9); step(6);
        apply_stimulus(4'b1011, 8'hA4); step(6);
        check_output("frame_none_yet", frame_count, 0);
        apply_stimulus(4'b0111, 8'hB0);
        step(4);
        check_output("frame_pre", frame_listo, 1'b0);
        step(1);
        check_output("frame_pulse", frame_listo, 1'b1);
        step(1);
        check_output("frame_one_cycle", frame_listo, 1'b0);
        check_output("frame_digitos", {digito3, digito2, digito1, digito0}, 16'h3210);
        check_output("frame_valido", valido, 4'hF);
        check_output("frame_count", frame_count, 1);

        // Unstable segments on digit 1: never four identical samples.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'b1101, (i % 2 == 0) ? 8'hA4 : 8'hB0);
            step(3);
        end
        check_output("toggle_digito1", digito1, 4'd1);
        check_output("toggle_valido", valido, 4'hF);

        // Two anodes low: remain waiting.
        apply_stimulus(4'b1100, 8'hC0);
        step(10);
        check_output("dual_digitos", {digito3, digito2, digito1, digito0}, 16'h3210);
        check_output("dual_valido", valido, 4'hF);

        // Blank code on digit 2 sets sticky error.
        apply_stimulus(4'b1011, 8'hFF);
        step(6);
        check_output("blank_digito2", digito2, 4'hF);
        check_output("blank_valido", valido, 4'b1011);
        check_output("blank_error", error_codigo, 1'b1);
        apply_stimulus(4'b1011, 8'h92);
        step(6);
        check_output("recap_digito2", digito2, 4'd5);
        check_output("recap_valido", valido, 4'hF);
        check_output("sticky_error", error_codigo, 1'b1);
        check_output("no_extra_frame", frame_count, 1);

        // Reset two cycles into a stable pattern discards everything.
        apply_stimulus(4'b0111, 8'h99);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_output("midreset_digitos", {digito3, digito2, digito1, digito0}, 16'h0000);
        check_output("midreset_valido", valido, 4'h0);
        check_output("midreset_error", error_codigo, 1'b0);
        step(4);
        check_output("postreset_pre", valido, 4'h0);
        step(1);
        check_output("postreset_digito3", digito3, 4'd4);
        check_output("postreset_valido", valido, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decodificador_visualizador_numerico.md
# decodificador_visualizador_numerico

Capture-side counterpart of the multiplexed numeric display driver. The block samples the shared 4-anode / 8-segment bus and waits for each anode/segment pattern to settle. It then decodes the segment code back to a BCD value and holds the four most recent digit values, with per-digit validity, a frame-complete pulse and a sticky decode-error flag. It sits beside the display driver at top level and serves self-check and read-back of the displayed value.

## Interface
- ESTABLE, default 4: consecutive identical registered samples required before capture; legal range 1..255.
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high.
- anodos  input  4  digit select, active-low one-hot; bit n low selects digit n.
- segmentos  input  8  segment code, active-low; bit0=a … bit6=g, bit7=dp (dp ignored).
- digito0..digito3  output  4 each  last captured BCD value per digit; 4'hF on undecodable code.
- valido  output  4  bit n = digito n holds a successfully decoded value.
- frame_listo  output  1  one-cycle pulse when all four digits have been captured since the previous pulse or reset.
- error_codigo  output  1  sticky; set on any undecodable capture; cleared only by reset.

## Operation
- Input stage: {anodos, segmentos} registered once into p_reg every cycle; all logic operates on p_reg.
- 8-bit counter cnt; p_prev holds the previous p_reg.
- FSM states:
  - ESPERA: p_reg anode field not exactly one low bit (all-high or ≥2 low); cnt=0. Go to FILTRO when the anode field becomes valid one-hot.
  - FILTRO: cnt increments while p_reg==p_prev. Any change of p_reg restarts cnt at 1 (new pattern counts as first sample). Capture when cnt reaches ESTABLE, then go to CAPTURADO. Invalid anode field returns to ESPERA.
  - CAPTURADO: no further capture of the same pattern. Any change goes to FILTRO (cnt=1), or to ESPERA if the anode field is invalid.
- Capture of digit n:
  - Decode segmentos[6:0] with the inverse table.
  - Valid code: digito n = value, valido[n]=1.
  - Invalid code: digito n = 4'hF, valido[n]=0, error_codigo=1.
  - Set visto[n] in either case.
- When visto becomes 4'b1111 on a capture: frame_listo=1 in that output cycle and visto clears to 0. Recapturing an already-seen digit does not advance the frame.
- Inverse table (active-high segments gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Every other pattern is invalid, including blank 00.
- Reset: state ESPERA, cnt=0, p_reg=8'hFF/anodos=4'hF (inactive), digito0..3=0, valido=0, visto=0, frame_listo=0, error_codigo=0.

## Timing
- Latency: bus held constant from edge 0 makes digito/valido update on edge ESTABLE+1 (5 with default), counting the input-register edge.
- Outputs are registered and change only on a capture edge (or reset). frame_listo is high exactly one cycle.
- A pattern change at any point before the capture edge aborts capture with no output change.
- With ESTABLE=1, capture occurs on the first cycle the one-hot pattern is in p_reg.
- Reset asserted mid-filter or mid-frame has priority: all state returns to reset values on that edge and the partial frame is discarded.
- cnt saturates at ESTABLE; no wrap.

## Structure
- Shared package visualizador_pkg: segment code constants SEG_0..SEG_9, state enum {ESPERA, FILTRO, CAPTURADO}, BCD_INVALIDO=4'hF.
- One sub-module: decodificador_7seg_bcd (combinational). Input 7-bit active-high segments; outputs 4-bit BCD and valid flag. The top inverts segmentos before it.

## Test plan
- Reset, then anodos=1110, segmentos=B0 held → digito0=3, valido=0001 on edge 5; no frame_listo.
- Sequence digits 0..3 with codes C0, F9, A4, B0, each held 6 cycles → digito0..3 = 0,1,2,3; valido=1111; single frame_listo pulse on the fourth capture edge.
- Digit 1 with segments toggling every 3 cycles (ESTABLE=4) → no capture; digito1/valido[1] unchanged.
- anodos=1100 held 10 cycles → stays ESPERA; no output change.
- Digit 2 code FF (blank) held → digito2=F, valido[2]=0, error_codigo=1 and remains 1 after later valid captures.
- Reset asserted 2 cycles into a stable pattern → all outputs 0; capture restarts, full ESTABLE+1 latency after reset deasserts.
